or_unit_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit OR/NOR logic unit (full32BitOr instance) between NREQ requesters in the pipeline CPU, e.g. the execute stage, the branch-compare helper and a debug port. Each requester presents operands and an orflag under a valid/ready handshake. The winning request is computed through the shared unit and captured in a single-entry result register. The result is returned under a valid/ready handshake, tagged with the requester id. A saturating completed-operation counter is provided for performance monitoring.

---
 rtl/or_unit_arbiter.sv | 118 +++++++++++
 tb/tb_or_unit_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/or_unit_arbiter.sv
// Round-robin arbiter sharing one 32-bit OR/NOR unit between NREQ requesters.
// The winning operation is captured in a single-entry result register tagged with the requester id.

module full32BitOr (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        orflag,
    output logic [31:0] out,
    output logic        carryout,
    output logic        overflow
);

    assign out      = orflag ? (a | b) : ~(a | b);
    assign carryout = 1'b0;
    assign overflow = 1'b0;

endmodule

module or_unit_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_orflag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_out,
    output logic [ID_W-1:0]      rsp_id,
    output logic [CNT_W-1:0]     ops_count
);

    logic [ID_W-1:0] ptr;
    logic            can_accept;
    logic            grant_hit;
    logic [ID_W-1:0] grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic            sel_orflag;
    logic [31:0]     unit_out;
    logic            unit_carryout;
    logic            unit_overflow;
    logic            unused_unit_flags;
    logic            transfer;
    logic            rsp_fire;

    assign can_accept = !rsp_valid || rsp_ready;

    // Two passes give wrap-around priority: indices above ptr first, then 0..ptr.
    // Grants are suppressed while reset is held so no requester sees an accept that is then discarded.
    always_comb begin
        grant_hit  = 1'b0;
        grant_idx  = '0;
        grant_vec  = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_orflag = 1'b0;
        if (can_accept && !reset) begin
            for (int unsigned pass = 0; pass < 2; pass++) begin
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (!grant_hit && req_valid[j] &&
                        ((pass == 0) ? (j > 32'(ptr)) : (j <= 32'(ptr)))) begin
                        grant_hit    = 1'b1;
                        grant_idx    = ID_W'(j);
                        grant_vec[j] = 1'b1;
                        sel_a        = req_a[j*32 +: 32];
                        sel_b        = req_b[j*32 +: 32];
                        sel_orflag   = req_orflag[j];
                    end
                end
            end
        end
    end

    assign req_ready = grant_vec;
    assign transfer  = grant_hit;
    assign rsp_fire  = rsp_valid && rsp_ready;

    full32BitOr u_or (
        .a        (sel_a),
        .b        (sel_b),
        .orflag   (sel_orflag),
        .out      (unit_out),
        .carryout (unit_carryout),
        .overflow (unit_overflow)
    );

    assign unused_unit_flags = unit_carryout | unit_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= ID_W'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_id    <= '0;
            ops_count <= '0;
        end else begin
            if (transfer) begin
                ptr       <= grant_idx;
                rsp_valid <= 1'b1;
                rsp_out   <= unit_out;
                rsp_id    <= grant_idx;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
            if (rsp_fire && (ops_count != '1)) begin
                ops_count <= ops_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Directed bench for or_unit_arbiter: OR/NOR results, round-robin order,
// backpressure, reset mid-operation and counter saturation.

module tb_or_unit_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 16;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_orflag;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [31:0]         rsp_out;
    logic [ID_W-1:0]     rsp_id;
    logic [CNT_W-1:0]    ops_count;

    int vectors;
    int miscompares;

    // Per-requester operands for the rotation tests, with hand-computed results.
    logic [31:0] tab_a   [NREQ] = '{32'h8000_0000, 32'h0F00_0000, 32'h00F0_0000, 32'h0000_0300};
    logic [31:0] tab_b   [NREQ] = '{32'h0000_0001, 32'h0000_0010, 32'h0000_0200, 32'h0000_0003};
    logic        tab_or  [NREQ] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] tab_out [NREQ] = '{32'h8000_0001, 32'hF0FF_FFEF, 32'h00F0_0200, 32'hFFFF_FCFC};
    int          order   [5]    = '{0, 1, 2, 3, 0};

    or_unit_arbiter #(
        .NREQ  (NREQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_orflag (req_orflag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_out    (rsp_out),
        .rsp_id     (rsp_id),
        .ops_count  (ops_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic orf);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_orflag[i]     = orf;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_orflag  = '0;
        rsp_ready   = 1'b0;

        // 1: reset, then a single OR request from requester 0
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_ops_count", 64'(ops_count), 64'd0);
        check("rst_rsp_out",   64'(rsp_out),   64'd0);
        check("rst_req_ready", 64'(req_ready), 64'b0000);
        set_req(0, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("t1_req_ready", 64'(req_ready), 64'b0001);
        tick();
        req_valid = '0;
        check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t1_rsp_out",   64'(rsp_out),   64'h0000_00FF);
        check("t1_rsp_id",    64'(rsp_id),    64'd0);
        rsp_ready = 1'b1;
        tick();
        check("t1_ops_count", 64'(ops_count), 64'd1);
        check("t1_drained",   64'(rsp_valid), 64'd0);

        // 2: NOR from requester 2
        rsp_ready = 1'b0;
        set_req(2, 32'hFFFF_0000, 32'h0000_00FF, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t2_req_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        check("t2_rsp_out", 64'(rsp_out), 64'h0000_FF00);
        check("t2_rsp_id",  64'(rsp_id),  64'd2);
        check("t2_ops_pre", 64'(ops_count), 64'd1);
        rsp_ready = 1'b1;
        tick();
        check("t2_ops_count", 64'(ops_count), 64'd2);

        // 3: move pointer to 3, then all four valid rotate 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) set_req(i, tab_a[i], tab_b[i], tab_or[i]);
        req_valid = 4'b1000;
        #1;
        check("t3_pre_ready", 64'(req_ready), 64'b1000);
        tick();
        check("t3_pre_id",  64'(rsp_id),  64'd3);
        check("t3_pre_out", 64'(rsp_out), 64'(tab_out[3]));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t3_ready_%0d", k), 64'(req_ready), 64'(4'b0001 << order[k]));
            tick();
            check($sformatf("t3_id_%0d", k),  64'(rsp_id),    64'(order[k]));
            check($sformatf("t3_out_%0d", k), 64'(rsp_out),   64'(tab_out[order[k]]));
            check($sformatf("t3_vld_%0d", k), 64'(rsp_valid), 64'd1);
        end
        check("t3_ops_count", 64'(ops_count), 64'd7);

        // 4: backpressure for 3 cycles, then drain and refill together
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t4_ready_%0d", c), 64'(req_ready), 64'b0000);
            check($sformatf("t4_id_%0d", c),    64'(rsp_id),    64'd0);
            check($sformatf("t4_out_%0d", c),   64'(rsp_out),   64'(tab_out[0]));
            tick();
        end
        check("t4_ops_hold", 64'(ops_count), 64'd7);
        rsp_ready = 1'b1;
        #1;
        check("t4_refill_ready", 64'(req_ready), 64'b0010);
        tick();
        check("t4_refill_vld", 64'(rsp_valid), 64'd1);
        check("t4_refill_id",  64'(rsp_id),    64'd1);
        check("t4_refill_out", 64'(rsp_out),   64'(tab_out[1]));
        check("t4_ops_count",  64'(ops_count), 64'd8);

        // 5: reset with a result pending, req1/req3 valid
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        tick();
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_ops_count", 64'(ops_count), 64'd0);
        check("t5_rsp_id",    64'(rsp_id),    64'd0);
        reset = 1'b0;
        #1;
        check("t5_ready_first", 64'(req_ready), 64'b0010);
        tick();
        check("t5_id_first",  64'(rsp_id),  64'd1);
        check("t5_out_first", 64'(rsp_out), 64'(tab_out[1]));
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1;
        check("t5_ready_second", 64'(req_ready), 64'b1000);
        tick();
        check("t5_id_second", 64'(rsp_id),    64'd3);
        check("t5_ops_one",   64'(ops_count), 64'd1);
        req_valid = '0;
        tick();
        check("t5_drained", 64'(rsp_valid), 64'd0);
        check("t5_ops_two", 64'(ops_count), 64'd2);

        // 6: counter saturation from 0xFFFE
        force dut.ops_count = 16'hFFFE;
        #1;
        release dut.ops_count;
        #1;
        check("t6_forced", 64'(ops_count), 64'hFFFE);
        req_valid = 4'b0001;
        tick();
        check("t6_load", 64'(ops_count), 64'hFFFE);
        tick();
        check("t6_first", 64'(ops_count), 64'hFFFF);
        tick();
        check("t6_second", 64'(ops_count), 64'hFFFF);
        req_valid = '0;
        tick();
        check("t6_third",  64'(ops_count), 64'hFFFF);
        check("t6_idle",   64'(rsp_valid), 64'd0);
        tick();
        check("t6_stay", 64'(ops_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
